// File: rtl/stdp_pkg.sv
// Shared types and arithmetic helpers for the STDP learning core.
package stdp_pkg;

   localparam int N_PRE_D = 4;
   localparam int TW_D    = 4;
   localparam int WW_D    = 8;

   typedef enum logic {IDLE, SWEEP} state_t;

   // w + ltp - ltd, clamped to the unsigned ww-bit weight range
   function automatic int sat_add(input int w, input int ltp, input int ltd, input int ww);
      int s;
      int wmax;
      s    = w + ltp - ltd;
      wmax = (1 << ww) - 1;
      if (s < 0)    return 0;
      if (s > wmax) return wmax;
      return s;
   endfunction

   function automatic int stdp_delta(input int dt, input int shift, input int win);
      return (dt < win) ? ((win - dt) >> shift) : 0;
   endfunction

endpackage

// File: rtl/stdp_spike_timer.sv
// Saturating cycles-since-last-spike timer; dt is the value the event sees this cycle.
module stdp_spike_timer #(
   parameter int TW = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          spike,
   output logic [TW-1:0] t,
   output logic [TW-1:0] dt
);

   always_comb dt = spike ? '0 : ((t == '1) ? t : t + 1'b1);

   always_ff @(posedge clk) begin
      if (rst) t <= '1;
      else     t <= dt;
   end

endmodule

// File: rtl/stdp_learner.sv
// Pair-based STDP core: serial LTP sweep on post spikes, parallel LTD on pre spikes.
module stdp_learner
   import stdp_pkg::*;
#(
   parameter int N_PRE     = N_PRE_D,
   parameter int TW        = TW_D,
   parameter int WW        = WW_D,
   parameter int W_INIT    = 128,
   parameter int WIN       = 8,
   parameter int LTP_SHIFT = 0,
   parameter int LTD_SHIFT = 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [N_PRE-1:0]    pre_spike,
   input  logic                post_spike,
   output logic [N_PRE*WW-1:0] weight,
   output logic [TW-1:0]       time_diff,
   output logic                busy,
   output logic                update_done,
   output logic                overrun
);

   localparam int IW = (N_PRE > 1) ? $clog2(N_PRE) : 1;

   logic [N_PRE-1:0][TW-1:0] unused_pre_t, dt_pre;
   logic [TW-1:0]            unused_post_t, dt_post;

   for (genvar g = 0; g < N_PRE; g++) begin : g_pre
      stdp_spike_timer #(.TW(TW)) u_pre_timer (
         .clk   (clk),
         .rst   (rst),
         .spike (pre_spike[g]),
         .t     (unused_pre_t[g]),
         .dt    (dt_pre[g])
      );
   end

   stdp_spike_timer #(.TW(TW)) u_post_timer (
      .clk   (clk),
      .rst   (rst),
      .spike (post_spike),
      .t     (unused_post_t),
      .dt    (dt_post)
   );

   state_t                   state;
   logic [IW-1:0]            idx;
   logic [N_PRE-1:0][TW-1:0] snap0, snap1;
   logic                     pend;
   logic                     last;

   assign last = (idx == IW'(N_PRE - 1));

   // snap0 feeds the active sweep; snap1 holds at most one queued post event
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         idx     <= '0;
         snap0   <= '0;
         snap1   <= '0;
         pend    <= 1'b0;
         overrun <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (post_spike) begin
                  snap0 <= dt_pre;
                  idx   <= '0;
                  state <= SWEEP;
               end
            end
            SWEEP: begin
               if (post_spike) begin
                  if (pend) overrun <= 1'b1;
                  else begin
                     snap1 <= dt_pre;
                     pend  <= 1'b1;
                  end
               end
               if (last) begin
                  idx <= '0;
                  // back-to-back sweep when an event is queued or arrives right now
                  if (pend) begin
                     snap0 <= snap1;
                     pend  <= 1'b0;
                  end else if (post_spike) begin
                     snap0 <= dt_pre;
                     pend  <= 1'b0;
                  end else begin
                     state <= IDLE;
                  end
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   logic [N_PRE-1:0][WW-1:0] w, w_next;
   int                       ltp_amt, ltd_amt;

   always_comb begin
      ltp_amt = (state == SWEEP) ? stdp_delta(int'(snap0[idx]), LTP_SHIFT, WIN) : 0;
      ltd_amt = post_spike ? 0 : stdp_delta(int'(dt_post), LTD_SHIFT, WIN);
      w_next  = w;
      for (int i = 0; i < N_PRE; i++) begin
         w_next[i] = WW'(sat_add(int'(w[i]),
                                 (state == SWEEP && idx == IW'(i)) ? ltp_amt : 0,
                                 pre_spike[i] ? ltd_amt : 0,
                                 WW));
      end
   end

   always_ff @(posedge clk) begin
      if (rst) w <= {N_PRE{WW'(W_INIT)}};
      else     w <= w_next;
   end

   assign weight      = w;
   assign busy        = (state == SWEEP);
   assign update_done = busy && last;
   assign time_diff   = busy ? snap0[idx] : '0;

endmodule

// File: tb/tb_stdp_learner.sv
// Bench for stdp_learner: spike-history model compared every cycle, plus pinned literals.
module tb_stdp_learner;

   localparam int N = 4, TW = 4, WW = 8, WIN = 8, TMAX = 15, WMAX = 255;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic [N-1:0]      pre_spike = '0;
   logic              post_spike = 1'b0;
   logic [N*WW-1:0]   weight;
   logic [TW-1:0]     time_diff;
   logic              busy, update_done, overrun;

   stdp_learner dut (
      .clk         (clk),
      .rst         (rst),
      .pre_spike   (pre_spike),
      .post_spike  (post_spike),
      .weight      (weight),
      .time_diff   (time_diff),
      .busy        (busy),
      .update_done (update_done),
      .overrun     (overrun)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   function automatic int clampt(input int x);
      return (x > TMAX) ? TMAX : x;
   endfunction

   function automatic int window(input int dt, input int shift);
      return (dt < WIN) ? ((WIN - dt) >> shift) : 0;
   endfunction

   function automatic int clampw(input int x);
      return (x < 0) ? 0 : ((x > WMAX) ? WMAX : x);
   endfunction

   // model: absolute spike times plus a queue of at most two sweep jobs
   int  m_w [N];
   int  m_last_pre [N];
   int  m_last_post;
   int  jobs [2][N];
   int  njobs;
   int  job_start;
   bit  m_ovr;
   bit  en = 1'b0;
   int  cyc = 0;

   always @(negedge clk) begin
      int  pos, dtq, d;
      int  dtp [N];
      bit  mbusy, done;
      mbusy = (njobs > 0);
      pos   = cyc - job_start;
      if (en) begin
         for (int i = 0; i < N; i++)
            chk($sformatf("model_w%0d", i), 32'(weight[i*WW +: WW]), 32'(m_w[i]));
         chk("model_busy", 32'(busy), 32'(mbusy));
         chk("model_update_done", 32'(update_done), 32'(mbusy && pos == N-1));
         chk("model_time_diff", 32'(time_diff), mbusy ? 32'(jobs[0][pos]) : 32'd0);
         chk("model_overrun", 32'(overrun), 32'(m_ovr));
      end
      if (rst) begin
         for (int i = 0; i < N; i++) begin
            m_w[i] = 128;
            m_last_pre[i] = -100;
         end
         m_last_post = -100;
         njobs = 0;
         job_start = 0;
         m_ovr = 1'b0;
         en = 1'b1;
      end else if (en) begin
         dtq = post_spike ? 0 : clampt(cyc - m_last_post);
         for (int i = 0; i < N; i++)
            dtp[i] = pre_spike[i] ? 0 : clampt(cyc - m_last_pre[i]);
         for (int i = 0; i < N; i++) begin
            d = 0;
            if (mbusy && pos == i) d += window(jobs[0][i], 0);
            if (pre_spike[i] && !post_spike) d -= window(dtq, 1);
            m_w[i] = clampw(m_w[i] + d);
         end
         done = mbusy && (pos == N-1);
         if (post_spike) begin
            if (njobs == 2) m_ovr = 1'b1;
            else if (njobs == 1) begin
               for (int i = 0; i < N; i++) jobs[1][i] = dtp[i];
               njobs = 2;
            end else begin
               for (int i = 0; i < N; i++) jobs[0][i] = dtp[i];
               njobs = 1;
               job_start = cyc + 1;
            end
         end
         if (done) begin
            for (int i = 0; i < N; i++) jobs[0][i] = jobs[1][i];
            njobs--;
            job_start = cyc + 1;
         end
         for (int i = 0; i < N; i++) if (pre_spike[i]) m_last_pre[i] = cyc;
         if (post_spike) m_last_post = cyc;
      end
      cyc++;
   end

   task automatic step(input logic [N-1:0] p, input logic q, input logic r);
      pre_spike  = p;
      post_spike = q;
      rst        = r;
      @(posedge clk);
      #1;
      pre_spike  = '0;
      post_spike = 1'b0;
      rst        = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) step('0, 1'b0, 1'b0);
   endtask

   task automatic do_reset();
      step('0, 1'b0, 1'b1);
      step('0, 1'b0, 1'b1);
   endtask

   function automatic logic [31:0] wt(input int i);
      return 32'(weight[i*WW +: WW]);
   endfunction

   initial begin
      @(posedge clk);
      #1;

      // reset state
      do_reset();
      for (int i = 0; i < N; i++) chk($sformatf("reset_w%0d", i), wt(i), 32'd128);
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_update_done", 32'(update_done), 32'd0);
      chk("reset_overrun", 32'(overrun), 32'd0);
      chk("reset_time_diff", 32'(time_diff), 32'd0);
      idle(2);

      // LTP: pre0 at c, post at c+3 -> +5 on w0
      step(4'b0001, 1'b0, 1'b0);
      idle(2);
      step('0, 1'b1, 1'b0);
      chk("ltp_busy_c4", 32'(busy), 32'd1);
      chk("ltp_time_diff_c4", 32'(time_diff), 32'd3);
      idle(1);
      chk("ltp_w0_c5", wt(0), 32'd133);
      idle(2);
      chk("ltp_update_done_c7", 32'(update_done), 32'd1);
      chk("ltp_w1", wt(1), 32'd128);
      idle(20);

      // LTD: post at c, pre2 at c+2 -> -3 on w2
      step('0, 1'b1, 1'b0);
      idle(1);
      step(4'b0100, 1'b0, 1'b0);
      chk("ltd_w2_c3", wt(2), 32'd125);
      idle(20);

      // simultaneous pre/post: +8 per sweep, clamp high
      do_reset();
      for (int k = 0; k < 20; k++) begin
         step(4'b1111, 1'b1, 1'b0);
         idle(9);
      end
      for (int i = 0; i < N; i++) chk($sformatf("sat_hi_w%0d", i), wt(i), 32'd255);

      // pre one cycle after post: -3 per event, clamp low
      for (int k = 0; k < 90; k++) begin
         step('0, 1'b1, 1'b0);
         step(4'b1111, 1'b0, 1'b0);
         idle(8);
      end
      for (int i = 0; i < N; i++) chk($sformatf("sat_lo_w%0d", i), wt(i), 32'd0);

      // post during sweep: c+1 queued, c+2 dropped
      do_reset();
      idle(2);
      step(4'b0001, 1'b0, 1'b0);
      step('0, 1'b1, 1'b0);
      step('0, 1'b1, 1'b0);
      step('0, 1'b1, 1'b0);
      chk("pend_overrun_c3", 32'(overrun), 32'd1);
      idle(1);
      chk("pend_done_c4", 32'(update_done), 32'd1);
      idle(1);
      chk("pend_busy_c5", 32'(busy), 32'd1);
      chk("pend_time_diff_c5", 32'(time_diff), 32'd2);
      idle(3);
      chk("pend_done_c8", 32'(update_done), 32'd1);
      idle(1);
      chk("pend_idle_c9", 32'(busy), 32'd0);
      chk("pend_w0", wt(0), 32'd141);
      idle(10);
      chk("pend_overrun_sticky", 32'(overrun), 32'd1);

      // collision: sweep writes ch1 (+6) while LTD hits ch1 (-3)
      do_reset();
      idle(2);
      step(4'b0010, 1'b0, 1'b0);
      idle(1);
      step('0, 1'b1, 1'b0);
      idle(1);
      step(4'b0010, 1'b0, 1'b0);
      chk("collide_w1", wt(1), 32'd131);
      idle(10);

      // reset at sweep idx 2 discards sweep and queued event
      step(4'b0001, 1'b0, 1'b0);
      step('0, 1'b1, 1'b0);
      step('0, 1'b1, 1'b0);
      idle(1);
      chk("rst_mid_w0_before", wt(0), 32'd135);
      step('0, 1'b0, 1'b1);
      chk("rst_mid_busy", 32'(busy), 32'd0);
      chk("rst_mid_w0", wt(0), 32'd128);
      idle(8);
      chk("rst_mid_no_pending", 32'(busy), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
